alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 155 +++++++++++++++
 tb/tb_alu_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU (ADD, INC, NEG, SUB) with
// Z/N/C/V flags.
//
// Stage S1 registers the operand set. The adder works combinationally from
// S1, and its output goes into stage S2, which registers the result and
// flags. Back-pressure from out_ready reaches in_ready combinationally, so
// the pipe runs at one op per cycle with no bubbles.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      async assert, active-low reset
//   in_valid   operand set presented
//   in_ready   block accepts the operand set this cycle
//   op         00 ADD (A+B), 01 INC (A+1), 10 NEG (-A), 11 SUB (B-A)
//   a, b       operands (b ignored for INC/NEG)
//   out_valid  result presented (S2 occupied)
//   out_ready  consumer takes the result this cycle
//   result     operation result
//   flags      {Z,N,C,V} of result
//   flags_q    {Z,N,C,V} of the most recently retired result
module alu_pipe #(
    parameter int WIDTH     = 32,
    parameter bit FLAG_HOLD = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [3:0]       flags_q
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_INC = 2'b01,
        OP_NEG = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [3:0]       flags;   // {Z,N,C,V}
    } rsp_t;

    logic s1_vld_q, s1_vld_d;
    req_t s1_q, s1_d;
    logic s2_vld_q, s2_vld_d;
    rsp_t s2_q, s2_d;

    logic s2_load, in_fire, out_fire;
    rsp_t alu_rsp;

    logic [WIDTH-1:0] x, y;
    logic             cin;
    logic [WIDTH:0]   sum;

    // Handshake. S2 takes S1 when it is empty or is draining this cycle.
    always_comb begin
        s2_load   = s1_vld_q && (!s2_vld_q || out_ready);
        in_ready  = !s1_vld_q || s2_load;
        in_fire   = in_valid && in_ready;
        out_fire  = s2_vld_q && out_ready;
        out_valid = s2_vld_q;
        result    = s2_q.result;
        flags     = s2_q.flags;
    end

    // All four ops map onto one adder, X + Y + cin.
    always_comb begin
        x   = '0;
        y   = '0;
        cin = 1'b0;
        case (s1_q.op)
            OP_ADD: begin x = s1_q.a;  y = s1_q.b;              end
            OP_INC: begin x = s1_q.a;               cin = 1'b1; end
            OP_NEG: begin x = ~s1_q.a;              cin = 1'b1; end
            OP_SUB: begin x = s1_q.b;  y = ~s1_q.a; cin = 1'b1; end
            default: ;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        alu_rsp.result = sum[WIDTH-1:0];
        alu_rsp.flags  = {(sum[WIDTH-1:0] == '0),
                          sum[WIDTH-1],
                          sum[WIDTH],
                          (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1])};
    end

    // Next state. Operands are captured only on an input transfer.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_d     = s1_q;
        s2_vld_d = s2_vld_q;
        s2_d     = s2_q;
        if (in_fire) begin
            s1_vld_d = 1'b1;
            s1_d     = '{op: op_e'(op), a: a, b: b};
        end else if (s2_load) begin
            s1_vld_d = 1'b0;
        end
        if (s2_load) begin
            s2_vld_d = 1'b1;
            s2_d     = alu_rsp;
        end else if (out_fire) begin
            s2_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_vld_q <= 1'b0;
            s2_q     <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_q     <= s1_d;
            s2_vld_q <= s2_vld_d;
            s2_q     <= s2_d;
        end
    end

    // Flags of the last retired result; captured only on an output transfer.
    generate
        if (FLAG_HOLD) begin : g_flag_hold
            logic [3:0] flags_hold_q, flags_hold_d;

            always_comb begin
                flags_hold_d = flags_hold_q;
                if (out_fire) flags_hold_d = s2_q.flags;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) flags_hold_q <= 4'h0;
                else        flags_hold_q <= flags_hold_d;
            end

            assign flags_q = flags_hold_q;
        end else begin : g_no_flag_hold
            assign flags_q = 4'h0;
        end
    endgenerate

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 32-bit instance: main pipeline/handshake target
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  op;
    logic [31:0] a, b, result;
    logic [3:0]  flags, flags_q;

    // 8-bit instance: narrow-width corner cases
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, result8;
    logic [3:0]  flags8, flags_q8;

    alu_pipe #(.WIDTH(32), .FLAG_HOLD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .flags_q(flags_q)
    );

    alu_pipe #(.WIDTH(8), .FLAG_HOLD(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .op(op8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .flags(flags8), .flags_q(flags_q8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic, flags from range tests.
    function automatic logic [67:0] model(input int w, input logic [1:0] o,
                                          input logic [63:0] av_in, input logic [63:0] bv_in);
        longint unsigned mask, av, bv, r;
        longint sa, sb, sv, smax, smin;
        logic c, v;
        mask = (64'd1 << w) - 64'd1;
        av   = av_in & mask;
        bv   = bv_in & mask;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -smax - 1;
        sa   = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
        sb   = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
        case (o)
            2'd0:    begin r = av + bv;  c = ((r >> w) != 0); sv = sa + sb; end
            2'd1:    begin r = av + 1;   c = (av == mask);    sv = sa + 1;  end
            2'd2:    begin r = 0 - av;   c = (av == 0);       sv = -sa;     end
            default: begin r = bv - av;  c = (bv >= av);      sv = sb - sa; end
        endcase
        v = (sv > smax) || (sv < smin);
        r = r & mask;
        return {r, (r == 0), r[w-1], c, v};
    endfunction

    typedef struct { logic [31:0] r; logic [3:0] f; } exp_t;
    exp_t sb[$];

    // Compare process: scoreboard of accepted ops, hold stability, flags_q.
    initial begin
        logic [3:0]  exp_fq;
        logic        hold_pend;
        logic [35:0] hold_val;
        logic [67:0] m;
        exp_t        e;
        exp_fq    = 4'h0;
        hold_pend = 1'b0;
        hold_val  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                exp_fq    = 4'h0;
                hold_pend = 1'b0;
                chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
                chk("rst_flags_q", {60'd0, flags_q}, 64'd0);
                chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
            end else begin
                chk("flags_q", {60'd0, flags_q}, {60'd0, exp_fq});
                if (hold_pend)
                    chk("hold_stable", {27'd0, out_valid, result, flags}, {27'd1, hold_val});
                hold_pend = 1'b0;
                if (out_valid) begin
                    if (out_ready) begin
                        if (sb.size() == 0) begin
                            chk("spurious_out", 64'd1, 64'd0);
                        end else begin
                            e = sb.pop_front();
                            chk("result", {32'd0, result}, {32'd0, e.r});
                            chk("flags", {60'd0, flags}, {60'd0, e.f});
                            exp_fq = e.f;
                        end
                    end else begin
                        hold_pend = 1'b1;
                        hold_val  = {result, flags};
                    end
                end
                if (in_valid && in_ready) begin
                    m = model(32, op, {32'd0, a}, {32'd0, b});
                    e.r = m[35:4];
                    e.f = m[3:0];
                    sb.push_back(e);
                end
            end
        end
    end

    // Present one op on the 32-bit DUT and hold it until accepted.
    task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; a = av; b = bv;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 20);
        if (!in_ready) chk("issue_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Empty pipe, out_ready=1: check two-cycle latency and literal values.
    task automatic directed(input string nm, input logic [1:0] o, input logic [31:0] av,
                            input logic [31:0] bv, input logic [31:0] er, input logic [3:0] ef);
        issue(o, av, bv);
        @(negedge clk);
        chk({nm, "_lat_early"}, {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk({nm, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({nm, "_result"}, {32'd0, result}, {32'd0, er});
        chk({nm, "_flags"}, {60'd0, flags}, {60'd0, ef});
    endtask

    task automatic directed8(input string nm, input logic [1:0] o, input logic [7:0] av,
                             input logic [7:0] bv, input logic [7:0] er, input logic [3:0] ef,
                             input bit use_lit);
        logic [67:0] m;
        m = model(8, o, {56'd0, av}, {56'd0, bv});
        @(posedge clk); #1;
        in_valid8 = 1'b1; op8 = o; a8 = av; b8 = bv;
        @(negedge clk);
        chk({nm, "_in_ready"}, {63'd0, in_ready8}, 64'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_valid"}, {63'd0, out_valid8}, 64'd1);
        if (use_lit) begin
            chk({nm, "_result"}, {56'd0, result8}, {56'd0, er});
            chk({nm, "_flags"}, {60'd0, flags8}, {60'd0, ef});
        end else begin
            chk({nm, "_result"}, {56'd0, result8}, {56'd0, m[11:4]});
            chk({nm, "_flags"}, {60'd0, flags8}, {60'd0, m[3:0]});
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  bp_op [4];
        logic [31:0] bp_a  [4];
        logic [31:0] bp_b  [4];
        int idx, cyc;
        bit go;

        rst_n = 1'b0;
        in_valid = 1'b0; op = 2'd0; a = '0; b = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; op8 = 2'd0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
        #1;
        chk("reset_result", {32'd0, result}, 64'd0);
        chk("reset_flags", {60'd0, flags}, 64'd0);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Literal corner cases
        directed("add_ovf", 2'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0101);
        directed("sub_eq", 2'd3, 32'd5, 32'd5, 32'h0, 4'b1010);
        directed("sub_borrow", 2'd3, 32'd6, 32'd5, 32'hFFFF_FFFF, 4'b0100);
        directed("neg_min", 2'd2, 32'h8000_0000, 32'h1234, 32'h8000_0000, 4'b0101);
        directed("neg_zero", 2'd2, 32'h0, 32'hFFFF, 32'h0, 4'b1010);
        directed("inc", 2'd1, 32'h7FFF_FFFF, 32'hDEAD, 32'h8000_0000, 4'b0101);
        directed8("inc8_wrap", 2'd1, 8'hFF, 8'h00, 8'h00, 4'b1010, 1'b1);
        directed8("add8_ovf", 2'd0, 8'h80, 8'h80, 8'h00, 4'b1011, 1'b1);
        for (int i = 0; i < 16; i++)
            directed8("rnd8", 2'($urandom), 8'($urandom), 8'($urandom), 8'h0, 4'h0, 1'b0);

        // Back-pressure: 4 back-to-back ops with out_ready low
        bp_op[0] = 2'd0; bp_a[0] = 32'd10;         bp_b[0] = 32'd20;
        bp_op[1] = 2'd2; bp_a[1] = 32'd1;          bp_b[1] = 32'd0;
        bp_op[2] = 2'd1; bp_a[2] = 32'hFFFF_FFFF;  bp_b[2] = 32'd0;
        bp_op[3] = 2'd3; bp_a[3] = 32'd5;          bp_b[3] = 32'd5;
        @(posedge clk); #1;
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1; op = bp_op[0]; a = bp_a[0]; b = bp_b[0];
        for (cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (cyc == 6) begin
                chk("bp_accepted", idx, 2);
                chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            end
            if (cyc >= 7 && cyc <= 10)
                chk("bp_retire_streak", {63'd0, out_valid}, 64'd1);
            go = in_valid && in_ready;
            @(posedge clk); #1;
            if (cyc == 6) out_ready = 1'b1;
            if (go) begin
                idx++;
                if (idx < 4) begin
                    op = bp_op[idx]; a = bp_a[idx]; b = bp_b[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("bp_all_accepted", idx, 4);
        chk("bp_drained", sb.size(), 0);

        // Fill both stages, then reset between edges
        out_ready = 1'b0;
        issue(2'd0, 32'd3, 32'd4);
        issue(2'd0, 32'd5, 32'd6);
        @(negedge clk);
        chk("full_out_valid", {63'd0, out_valid}, 64'd1);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("pre_rst_flags_q", {60'd0, flags_q}, {60'd0, 4'b1010});
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_flags_q", {60'd0, flags_q}, 64'd0);
        chk("mid_rst_result", {32'd0, result}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        directed("post_rst", 2'd3, 32'd1, 32'd10, 32'd9, 4'b0010);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            op = 2'($urandom);
            a  = pick();
            b  = pick();
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("final_drained", sb.size(), 0);
        chk("final_out_valid", {63'd0, out_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
